// File: rtl/sfp_to_fix_pipe.sv
// ============================================================================
// Module  : sfp_to_fix_pipe
// Brief   : Multi-lane, two-stage sfp {sign,exp,sig} -> two's-complement fixed
//           point converter. Optional SFP2FIX_SAT_EN saturates on overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sfp_to_fix_pipe #(
  parameter int EXP_WIDTH = 4,
  parameter int SIG_WIDTH = 4,
  parameter int BIAS      = 8,
  parameter int FRAC_BITS = 11,
  parameter int FIX_WIDTH = 21,
  parameter int LANES     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0] sfp_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES*FIX_WIDTH-1:0]              fix_out,
  output logic [LANES-1:0]                        ovf
);

  localparam int SFP_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int EXP_MAX   = (1 << EXP_WIDTH) - 1;
  localparam int MAX_LSH   = (EXP_MAX > BIAS) ? (EXP_MAX - BIAS) : 0;
  localparam int MAG_RAW   = FRAC_BITS + 1 + MAX_LSH;
  localparam int MAG_W     = (MAG_RAW > FIX_WIDTH) ? MAG_RAW : FIX_WIDTH;
  localparam int ALIGN     = FRAC_BITS - SIG_WIDTH;

  logic                          pipe_en;
  logic                          s1_valid_q;
  logic [LANES*SFP_WIDTH-1:0]    s1_data_q;
  logic                          out_valid_q;
  logic [LANES*FIX_WIDTH-1:0]    fix_q;
  logic [LANES*FIX_WIDTH-1:0]    fix_d;
  logic [LANES-1:0]              ovf_q;
  logic [LANES-1:0]              ovf_d;

  // Whole pipeline advances together; a stalled output freezes both stages.
  assign pipe_en   = out_ready | ~out_valid_q;
  assign in_ready  = pipe_en;
  assign out_valid = out_valid_q;
  assign fix_out   = fix_q;
  assign ovf       = ovf_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic                 sign;
    logic                 zero;
    logic [EXP_WIDTH-1:0] expo;
    logic [SIG_WIDTH-1:0] sig;
    logic [MAG_W-1:0]     mag0;
    logic [MAG_W-1:0]     mag;
    logic [FIX_WIDTH-1:0] mag_lo;
    logic [FIX_WIDTH-1:0] wrapped;
    logic [FIX_WIDTH-1:0] res;
    logic                 ovf_raw;
    int                   sh;

    assign {sign, expo, sig} = s1_data_q[i*SFP_WIDTH +: SFP_WIDTH];
    assign zero = (expo == '0);
    assign mag0 = {{(MAG_W-SIG_WIDTH-1){1'b0}}, ~zero, sig} << ALIGN;

    // MAG_W covers the largest left shift, so only right shifts drop bits.
    always_comb begin
      sh  = int'(expo) - BIAS;
      mag = '0;
      if (sh >= 0) mag = mag0 << sh;
      else         mag = mag0 >> (-sh);
    end

    assign ovf_raw = |mag[MAG_W-1:FIX_WIDTH-1];
    assign mag_lo  = mag[FIX_WIDTH-1:0];
    assign wrapped = sign ? (~mag_lo + 1'b1) : mag_lo;

    always_comb begin
      res = '0;
`ifdef SFP2FIX_SAT_EN
      if (ovf_raw)
        res = sign ? {1'b1, {(FIX_WIDTH-1){1'b0}}} : {1'b0, {(FIX_WIDTH-1){1'b1}}};
      else
        res = wrapped;
`else
      res = wrapped;
`endif
      if (zero) res = '0;
    end

    assign fix_d[i*FIX_WIDTH +: FIX_WIDTH] = res;
    assign ovf_d[i]                        = ovf_raw & ~zero;
  end : g_lane

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      fix_q       <= '0;
      ovf_q       <= '0;
    end else if (pipe_en) begin
      s1_valid_q  <= in_valid;
      s1_data_q   <= sfp_in;
      out_valid_q <= s1_valid_q;
      fix_q       <= fix_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sfp_to_fix_pipe.sv
// ============================================================================
// Module  : tb_sfp_to_fix_pipe
// Brief   : Scoreboard bench for sfp_to_fix_pipe (default and 16-bit builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sfp_to_fix_pipe;

  localparam int W    = 9;
  localparam int FW   = 21;
  localparam int NL   = 4;
  localparam int FRAC = 11;
  localparam int BIAS = 8;

  typedef struct {
    logic [NL*FW-1:0] fix;
    logic [NL-1:0]    ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [NL*W-1:0]   sfp_in;
  logic [NL*FW-1:0]  fix_out;
  logic [NL-1:0]     ovf;

  logic              v16, rdy16, ov16;
  logic [NL*W-1:0]   in16;
  logic [NL*16-1:0]  fo16;
  logic [NL-1:0]     ovf16;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_fail   = 0;
  int                n_out    = 0;
  logic              held     = 1'b0;
  logic [NL*FW-1:0]  held_fix;

  always #5 clk = ~clk;

  sfp_to_fix_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sfp_in(sfp_in), .out_valid(out_valid), .out_ready(out_ready),
    .fix_out(fix_out), .ovf(ovf)
  );

  sfp_to_fix_pipe #(.FIX_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .sfp_in(in16), .out_valid(ov16), .out_ready(1'b1),
    .fix_out(fo16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: value = (1 + m/16) * 2^(e-BIAS), scaled by 2^FRAC and truncated.
  function automatic void model_lane(input logic [W-1:0] w, input int fw,
                                     output longint unsigned fix, output logic o);
    longint unsigned mag, lim;
    int e, m;
    e   = int'(w[7:4]);
    m   = int'(w[3:0]);
    fix = 0;
    o   = 1'b0;
    if (e != 0) begin
      mag = (longint'(16 + m) << (e + FRAC - 4)) >> BIAS;
      lim = 64'd1 << (fw - 1);
      o   = (mag >= lim);
      fix = w[8] ? (~mag + 64'd1) : mag;
      fix = fix & ((lim << 1) - 64'd1);
`ifdef SFP2FIX_SAT_EN
      if (o) fix = w[8] ? lim : (lim - 64'd1);
`endif
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (held) check("hold_stable", {out_valid, fix_out}, {1'b1, held_fix});
      if (in_valid && in_ready) begin
        exp_t e;
        longint unsigned f;
        logic o;
        for (int i = 0; i < NL; i++) begin
          model_lane(sfp_in[i*W +: W], FW, f, o);
          e.fix[i*FW +: FW] = f[FW-1:0];
          e.ovf[i]          = o;
        end
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_fix", fix_out, e.fix);
          check("sb_ovf", ovf, e.ovf);
        end
        n_out++;
      end
      held     = out_valid && !out_ready;
      held_fix = fix_out;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [NL*W-1:0] d);
    int k;
    k        = 0;
    in_valid = 1'b1;
    sfp_in   = d;
    #1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    check("send_timeout", 128'(k < 100), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    logic [NL*W-1:0] grp [8];
    logic [63:0]     r;
    int              sent, cyc, n0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sfp_in = '0;
    v16 = 1'b0; in16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_fix",       fix_out,   0);
    check("rst_ovf",       ovf,       0);
    check("rst_in_ready",  in_ready,  1);
    rst = 1'b0;
    @(posedge clk); #1;

    // +1.0 on lane 0
    out_ready = 1'b1;
    send({9'h000, 9'h000, 9'h000, 9'h080});
    @(posedge clk); #1;
    check("t1_valid", out_valid,     1);
    check("t1_lane0", fix_out[20:0], 21'h000800);
    check("t1_ovf",   ovf,           0);

    // 2^-7, -1.0, zero with sign set, +248.0
    send({9'h0FF, 9'h105, 9'h180, 9'h010});
    @(posedge clk); #1;
    check("t2_valid", out_valid,       1);
    check("t2_lane0", fix_out[20:0],   21'h000010);
    check("t2_lane1", fix_out[41:21],  21'h1FF800);
    check("t2_lane2", fix_out[62:42],  21'h000000);
    check("t2_lane3", fix_out[83:63],  21'h07C000);
    check("t2_ovf",   ovf,             0);

    // 16-bit output: overflow, negative overflow, in-range, exact 2^15 negative
    check("t4_ready", rdy16, 1);
    v16  = 1'b1;
    in16 = {9'h1C0, 9'h080, 9'h1FF, 9'h0FF};
    @(posedge clk); #1;
    v16 = 1'b0;
    @(posedge clk); #1;
    check("t4_valid", ov16, 1);
`ifdef SFP2FIX_SAT_EN
    check("t4_lane0", fo16[15:0],  16'h7FFF);
    check("t4_lane1", fo16[31:16], 16'h8000);
`else
    check("t4_lane0", fo16[15:0],  16'hC000);
    check("t4_lane1", fo16[31:16], 16'h4000);
`endif
    check("t4_lane2", fo16[47:32], 16'h0800);
    check("t4_lane3", fo16[63:48], 16'h8000);
    check("t4_ovf",   ovf16,       4'b1011);

    // 8 groups with out_ready toggling every cycle
    for (int i = 0; i < 8; i++) begin
      r      = {$urandom(), $urandom()};
      grp[i] = r[NL*W-1:0];
    end
    n0 = n_out; sent = 0; cyc = 0;
    while (sent < 8 && cyc < 100) begin
      out_ready = cyc[0];
      in_valid  = 1'b1;
      sfp_in    = grp[sent];
      #1;
      if (in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    check("t3_sent", 128'(sent), 128'd8);
    drain("t3_drained");
    check("t3_count", 128'(n_out - n0), 128'd8);

    // reset with two groups in flight and output stalled
    out_ready = 1'b0;
    send({9'h000, 9'h000, 9'h000, 9'h0FF});
    send({9'h000, 9'h000, 9'h000, 9'h180});
    check("t5_stalled", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_fix",       fix_out,   0);
    check("t5_ovf",       ovf,       0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send({9'h000, 9'h000, 9'h000, 9'h080});
    @(posedge clk); #1;
    check("t5_post_valid", out_valid,     1);
    check("t5_post_lane0", fix_out[20:0], 21'h000800);

    // random data, random handshake
    for (int c = 0; c < 12000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      r         = {$urandom(), $urandom()};
      sfp_in    = r[NL*W-1:0];
      @(posedge clk); #1;
    end
    drain("t6_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
